// File: rtl/circuito_exp5_if.sv
// rtl/circuito_exp5_if.sv - player/status/debug bundle of the memory-sequence game
interface circuito_exp5_if;
  logic       iniciar;
  logic [3:0] chaves;
  logic       acertou;
  logic       errou;
  logic       pronto;
  logic [3:0] leds;
  logic       db_igual;
  logic [6:0] db_contagem;
  logic [6:0] db_memoria;
  logic [6:0] db_estado;
  logic [6:0] db_jogadafeita;
  logic       db_clock;
  logic       db_iniciar;
  logic       db_tem_jogada;

  modport master (
    output iniciar, chaves,
    input  acertou, errou, pronto, leds, db_igual, db_contagem, db_memoria,
           db_estado, db_jogadafeita, db_clock, db_iniciar, db_tem_jogada
  );

  modport slave (
    input  iniciar, chaves,
    output acertou, errou, pronto, leds, db_igual, db_contagem, db_memoria,
           db_estado, db_jogadafeita, db_clock, db_iniciar, db_tem_jogada
  );
endinterface

// File: rtl/circuito_exp5.sv
// rtl/circuito_exp5.sv - memory-sequence game datapath and control; DB_DISPLAYS_EN enables the four 7-seg debug displays
module circuito_exp5 (
  input  logic             clock,
  input  logic             reset,
  circuito_exp5_if.slave   bus
);

  typedef enum logic [3:0] {
    inicial       = 4'h0,
    preparacao    = 4'h1,
    espera_jogada = 4'h2,
    registra      = 4'h4,
    comparacao    = 4'h5,
    proximo       = 4'h6,
    fim_acertou   = 4'hA,
    fim_errou     = 4'hE
  } estado_t;

  estado_t    estado, proximo_estado;
  logic [3:0] contagem;
  logic [3:0] jogada;
  logic [3:0] memoria;
  logic       tem_jogada;
  logic       tem_anterior;
  logic       jogada_feita;
  logic       igual;
  logic       fim_c;
  logic       zera_c, conta_c, zera_r, registra_r;

  always_comb begin
    memoria = 4'b0001;
    case (contagem)
      4'h0: memoria = 4'b0001;
      4'h1: memoria = 4'b0010;
      4'h2: memoria = 4'b0100;
      4'h3: memoria = 4'b1000;
      4'h4: memoria = 4'b0100;
      4'h5: memoria = 4'b0010;
      4'h6: memoria = 4'b0001;
      4'h7: memoria = 4'b0001;
      4'h8: memoria = 4'b0010;
      4'h9: memoria = 4'b0010;
      4'hA: memoria = 4'b0100;
      4'hB: memoria = 4'b0100;
      4'hC: memoria = 4'b1000;
      4'hD: memoria = 4'b1000;
      4'hE: memoria = 4'b0001;
      4'hF: memoria = 4'b0100;
      default: memoria = 4'b0001;
    endcase
  end

  assign tem_jogada = |bus.chaves;
  assign igual      = (jogada == memoria);
  assign fim_c      = (contagem == 4'hF);

  // Registered pulse: one play per 0 -> nonzero transition of the switches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tem_anterior <= 1'b0;
      jogada_feita <= 1'b0;
    end else begin
      tem_anterior <= tem_jogada;
      jogada_feita <= tem_jogada & ~tem_anterior;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      contagem <= 4'h0;
    else if (zera_c)
      contagem <= 4'h0;
    else if (conta_c)
      contagem <= contagem + 4'h1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      jogada <= 4'h0;
    else if (zera_r)
      jogada <= 4'h0;
    else if (registra_r)
      jogada <= bus.chaves;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      estado <= inicial;
    else
      estado <= proximo_estado;
  end

  always_comb begin
    proximo_estado = estado;
    zera_c         = 1'b0;
    zera_r         = 1'b0;
    registra_r     = 1'b0;
    conta_c        = 1'b0;
    case (estado)
      inicial:       if (bus.iniciar) proximo_estado = preparacao;
      preparacao: begin
        zera_c         = 1'b1;
        zera_r         = 1'b1;
        proximo_estado = espera_jogada;
      end
      espera_jogada: if (jogada_feita) proximo_estado = registra;
      registra: begin
        registra_r     = 1'b1;
        proximo_estado = comparacao;
      end
      comparacao: begin
        if (!igual)
          proximo_estado = fim_errou;
        else if (fim_c)
          proximo_estado = fim_acertou;
        else
          proximo_estado = proximo;
      end
      proximo: begin
        conta_c        = 1'b1;
        proximo_estado = espera_jogada;
      end
      fim_acertou,
      fim_errou:     if (bus.iniciar) proximo_estado = preparacao;
      default:       proximo_estado = inicial;
    endcase
  end

  assign bus.acertou       = (estado == fim_acertou);
  assign bus.errou         = (estado == fim_errou);
  assign bus.pronto        = (estado == fim_acertou) || (estado == fim_errou);
  assign bus.leds          = jogada;
  assign bus.db_igual      = igual;
  assign bus.db_clock      = clock;
  assign bus.db_iniciar    = bus.iniciar;
  assign bus.db_tem_jogada = tem_jogada;

`ifdef DB_DISPLAYS_EN
  // Segments in gfedcba order, 0 lights the segment.
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0: hex7seg = 7'b1000000;
      4'h1: hex7seg = 7'b1111001;
      4'h2: hex7seg = 7'b0100100;
      4'h3: hex7seg = 7'b0110000;
      4'h4: hex7seg = 7'b0011001;
      4'h5: hex7seg = 7'b0010010;
      4'h6: hex7seg = 7'b0000010;
      4'h7: hex7seg = 7'b1111000;
      4'h8: hex7seg = 7'b0000000;
      4'h9: hex7seg = 7'b0010000;
      4'hA: hex7seg = 7'b0001000;
      4'hB: hex7seg = 7'b0000011;
      4'hC: hex7seg = 7'b1000110;
      4'hD: hex7seg = 7'b0100001;
      4'hE: hex7seg = 7'b0000110;
      default: hex7seg = 7'b0001110;
    endcase
  endfunction

  assign bus.db_contagem    = hex7seg(contagem);
  assign bus.db_memoria     = hex7seg(memoria);
  assign bus.db_estado      = hex7seg(estado);
  assign bus.db_jogadafeita = hex7seg(jogada);
`else
  assign bus.db_contagem    = 7'b1111111;
  assign bus.db_memoria     = 7'b1111111;
  assign bus.db_estado      = 7'b1111111;
  assign bus.db_jogadafeita = 7'b1111111;
`endif

endmodule

// File: tb/tb_circuito_exp5.sv
// tb/tb_circuito_exp5.sv - randomized game sessions against a sequence-level reference model
module tb_circuito_exp5;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  circuito_exp5_if bus ();

  circuito_exp5 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [3:0] rom [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                          4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};
  // Lit segments (1 = on) in gfedcba order, per hex glyph.
  logic [6:0] lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int         exp_addr;
  int         exp_result;
  logic [3:0] exp_leds;

  function automatic logic [6:0] disp(input int v);
`ifdef DB_DISPLAYS_EN
    disp = ~lit[v & 15];
`else
    disp = 7'h7F;
`endif
  endfunction

  function automatic int code_of(input int result);
    code_of = (result == 1) ? 10 : (result == 2) ? 14 : 2;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status();
    chk("acertou", bus.acertou, exp_result == 1);
    chk("errou", bus.errou, exp_result == 2);
    chk("pronto", bus.pronto, exp_result != 0);
  endtask

  task automatic play(input logic [3:0] v, input int hold, input int gap);
    logic ok;
    ok = (v == rom[exp_addr]);
    bus.chaves = v;
    step(1);
    chk("tem_jogada", bus.db_tem_jogada, 1);
    step(2);
    chk("igual_cmp", bus.db_igual, ok);
    chk("leds_cmp", bus.leds, v);
    chk("mem_cmp", bus.db_memoria, disp(rom[exp_addr]));
    chk("jogada_disp", bus.db_jogadafeita, disp(v));
    exp_leds = v;
    if (!ok) exp_result = 2;
    else if (exp_addr == 15) exp_result = 1;
    else exp_addr++;
    step(1);
    chk_status();
    step(hold - 4);
    bus.chaves = 4'h0;
    step(gap);
    chk("contagem", bus.db_contagem, disp(exp_addr));
    chk("estado", bus.db_estado, disp(code_of(exp_result)));
    chk("leds_hold", bus.leds, exp_leds);
  endtask

  task automatic restart();
    bus.iniciar = 1'b1;
    step(1);
    chk("db_iniciar", bus.db_iniciar, 1);
    bus.iniciar = 1'b0;
    step(2);
    exp_addr = 0; exp_result = 0; exp_leds = 4'h0;
    chk_status();
    chk("leds_restart", bus.leds, 0);
    chk("cont_restart", bus.db_contagem, disp(0));
    chk("estado_restart", bus.db_estado, disp(2));
  endtask

  task automatic wrong_play(input int hold, input int gap);
    logic [3:0] v;
    v = 4'($urandom_range(1, 15));
    while (v == rom[exp_addr]) v = 4'($urandom_range(1, 15));
    play(v, hold, gap);
  endtask

  initial begin
    checks = 0; errors = 0;
    exp_addr = 0; exp_result = 0; exp_leds = 4'h0;
    bus.iniciar = 1'b0;
    bus.chaves  = 4'h0;
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
    chk_status();
    chk("leds_reset", bus.leds, 0);
    chk("estado_reset", bus.db_estado, disp(0));
    chk("cont_reset", bus.db_contagem, disp(0));
    chk("db_clock", bus.db_clock, 0);
    chk("tem_idle", bus.db_tem_jogada, 0);

    bus.iniciar = 1'b1;
    step(1);
    chk("estado_prep", bus.db_estado, disp(1));
    step(4);
    chk("estado_wait", bus.db_estado, disp(2));
    chk("cont_wait", bus.db_contagem, disp(0));
    chk("pronto_wait", bus.pronto, 0);
    bus.iniciar = 1'b0;
    step(1);

    play(4'b0001, 10, 10);
    play(4'b0010, 10, 10);
    play(4'b0100, 10, 10);
    chk("cont_three", bus.db_contagem, disp(3));
    play(4'b0001, 5, 5);
    chk("errou_end", bus.errou, 1);
    chk("leds_wrong", bus.leds, 4'b0001);
    chk("estado_e", bus.db_estado, disp(14));
    chk("cont_fail", bus.db_contagem, disp(3));

    restart();
    for (int i = 0; i < 16; i++)
      play(rom[i], $urandom_range(4, 12), $urandom_range(2, 10));
    chk("acertou_end", bus.acertou, 1);
    chk("estado_a", bus.db_estado, disp(10));
    chk("cont_f", bus.db_contagem, disp(15));
    step(3);
    chk_status();

    for (int g = 0; g < 8; g++) begin
      int n;
      restart();
      n = $urandom_range(0, 16);
      for (int i = 0; i < 16 && exp_result == 0; i++) begin
        if (i < n) play(rom[exp_addr], $urandom_range(4, 9), $urandom_range(2, 6));
        else wrong_play($urandom_range(4, 9), $urandom_range(2, 6));
      end
      chk("game_done", bus.pronto, 1);
    end

    restart();
    for (int i = 0; i < 5; i++)
      play(rom[exp_addr], $urandom_range(4, 8), $urandom_range(2, 5));
    chk("cont_five", bus.db_contagem, disp(5));
    bus.chaves = rom[exp_addr];
    #2;
    reset = 1'b0;
    #1;
    exp_addr = 0; exp_result = 0; exp_leds = 4'h0;
    chk_status();
    chk("leds_async", bus.leds, 0);
    chk("cont_async", bus.db_contagem, disp(0));
    chk("estado_async", bus.db_estado, disp(0));
    @(negedge clock);
    bus.chaves = 4'h0;
    reset = 1'b1;
    step(3);
    chk("estado_after", bus.db_estado, disp(0));
    chk_status();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
